// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
// Covers M-extension funct3 codes, shared-ALU controls and FSM states.
package muldiv_seq_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction and result selection for multiply/divide.
// Purely combinational; the shared ALU is not used here.
module muldiv_signfix
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic            neg,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] res
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    assign prod = neg ? -{hi, lo} : {hi, lo};
    assign quo  = neg ? -lo : lo;
    assign rem  = neg ? -hi : hi;

    always_comb begin
        res = '0;
        unique case (op)
            OP_MUL:                      res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             res = quo;
            default:                     res = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer borrowing the shared ALU.
// {hi,lo} holds the product for multiplies and {remainder,quotient} for divides.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] rs1_q, rs2_q, hi_q, lo_q, result_q;
    logic [4:0]      cnt_q;
    logic            neg_q, spec_q;

    logic            is_mul, sgn_a, sgn_b, neg1, neg2;
    logic [XLEN-1:0] abs1, abs2, spec_val, fix_val;
    logic            div0, ovf, special, neg_res;
    logic [XLEN:0]   shifted;
    logic            carry, sub_ok;

    assign is_mul = ~op_q[2];
    assign sgn_a  = (op_q != OP_MULHU) & (op_q != OP_DIVU) & (op_q != OP_REMU);
    assign sgn_b  = sgn_a & (op_q != OP_MULHSU);
    assign neg1   = sgn_a & rs1_q[XLEN-1];
    assign neg2   = sgn_b & rs2_q[XLEN-1];
    assign abs1   = neg1 ? -rs1_q : rs1_q;
    assign abs2   = neg2 ? -rs2_q : rs2_q;

    // Remainder sign follows the dividend only.
    assign neg_res = (~is_mul & op_q[1]) ? neg1 : (neg1 ^ neg2);

    assign div0 = op_q[2] & (rs2_q == '0);
    assign ovf  = op_q[2] & ~op_q[0] & (rs2_q == '1) &
                  (rs1_q == {1'b1, {(XLEN-1){1'b0}}});
    assign special = div0 | ovf;

    always_comb begin
        spec_val = '0;
        if (div0)
            spec_val = op_q[1] ? rs1_q : '1;
        else if (!op_q[1])
            spec_val = {1'b1, {(XLEN-1){1'b0}}};
    end

    assign shifted = {hi_q, lo_q[XLEN-1]};

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (state_q == S_ITER) begin
            if (is_mul) begin
                alu_a = hi_q;
                alu_b = lo_q[0] ? abs1 : '0;
            end else begin
                alu_a    = shifted[XLEN-1:0];
                alu_b    = abs2;
                alu_ctrl = ALU_SUB;
            end
        end
    end

    assign carry  = alu_result < alu_a;
    assign sub_ok = shifted[XLEN] | (shifted[XLEN-1:0] >= abs2);

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op  (op_q),
        .neg (neg_q),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (fix_val)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = special ? S_FIX : S_ITER;
            S_ITER:  if (cnt_q == 5'(ITERS-1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = start ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= op;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                    end
                end
                S_PREP: begin
                    hi_q   <= '0;
                    lo_q   <= special ? spec_val : (is_mul ? abs2 : abs1);
                    spec_q <= special;
                    neg_q  <= neg_res;
                    cnt_q  <= '0;
                end
                S_ITER: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (is_mul) begin
                        hi_q <= {carry, alu_result[XLEN-1:1]};
                        lo_q <= {alu_result[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_q <= sub_ok ? alu_result : shifted[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], sub_ok};
                    end
                end
                S_FIX: result_q <= spec_q ? lo_q : fix_val;
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == S_PREP) | (state_q == S_ITER) | (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural shared ALU.
// Expected values are hand-computed RV32M results.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;

    int checks   = 0;
    int failures = 0;
    int lat, n_busy, n_sub, n_done;

    always #5 clk = ~clk;

    assign alu_result = (alu_ctrl == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

    muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat    = 0;
        n_busy = busy ? 1 : 0;
        n_sub  = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) n_busy++;
            if (alu_ctrl == 4'b0001) n_sub++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        issue(o, a, b);
        wait_done();
        check(tag, result, exp);
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        rs1   = '0;
        rs2   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done();
        check("mul_neg", result, 32'hFFFF_FFEB);
        check("mul_lat", lat, 34);
        check("mul_busy_cycles", n_busy, 34);
        check("mul_no_sub", n_sub, 0);
        @(posedge clk);
        #1;

        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);

        issue(3'b101, 32'd100, 32'd7);
        wait_done();
        check("divu", result, 32'd14);
        check("divu_sub_cycles", n_sub, 32);
        @(posedge clk);
        #1;
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);

        run("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        issue(3'b101, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        op    = 3'b100;
        rs1   = 32'd5;
        rs2   = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        check("ignore_start", result, 32'd14);
        check("ignore_lat", lat, 22);
        @(posedge clk);
        #1;

        issue(3'b000, 32'd7, 32'd9);
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        issue(3'b101, 32'd100, 32'd7);
        wait_done();
        check("b2b_first", result, 32'd14);
        issue(3'b101, 32'd9, 32'd3);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        check("b2b_held", result, 32'd14);
        wait_done();
        check("b2b_second", result, 32'd3);
        check("b2b_lat", lat, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
